// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the command master.
//   - AXI response codes (OKAY, EXOKAY, SLVERR, DECERR)
//   - Master FSM state encoding
//   - Default protection value driven on AWPROT/ARPROT
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Unprivileged, secure, data access.
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WR_B  = 3'd2,
    ST_RD_AR = 3'd3,
    ST_RD_R  = 3'd4,
    ST_RSP   = 3'd5
  } state_e;

endpackage

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master.
// Takes one register command from a valid/ready stream, runs exactly one
// AXI4-Lite read or write, and returns the result on a valid/ready stream.
// Ports:
//   aclk, aresetn          clock, synchronous active-low reset
//   cmd_*                  command stream (rnw, addr, wdata, wstrb)
//   rsp_*                  response stream (rnw echo, rdata, resp)
//   m_axi_*                AXI4-Lite master port (AW, W, B, AR, R)
// Every output is a flop, so no valid depends combinationally on a ready.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int AXI_ALEN = 64,
  parameter int AXI_DLEN = 64,
  parameter int AXI_SLEN = AXI_DLEN / 8
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_rnw,
  input  logic [AXI_ALEN-1:0] cmd_addr,
  input  logic [AXI_DLEN-1:0] cmd_wdata,
  input  logic [AXI_SLEN-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_rnw,
  output logic [AXI_DLEN-1:0] rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [AXI_ALEN-1:0] m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  output logic [AXI_DLEN-1:0] m_axi_wdata,
  output logic [AXI_SLEN-1:0] m_axi_wstrb,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  input  logic [1:0]          m_axi_bresp,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  output logic [AXI_ALEN-1:0] m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  input  logic [AXI_DLEN-1:0] m_axi_rdata,
  input  logic [1:0]          m_axi_rresp
);

  state_e              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [AXI_ALEN-1:0] addr_q, addr_d;
  logic [AXI_DLEN-1:0] wdata_q, wdata_d;
  logic [AXI_SLEN-1:0] wstrb_q, wstrb_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_rnw_q, rsp_rnw_d;
  logic [AXI_DLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;

  // A write channel is finished once its valid has dropped, or it is
  // handshaking right now. The valid flops double as the done flags.
  logic aw_done, w_done;
  assign aw_done = !awvalid_q || m_axi_awready;
  assign w_done  = !wvalid_q  || m_axi_wready;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rnw_d   = rsp_rnw_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      ST_IDLE: begin
        // cmd_ready comes up one cycle after reset release / response.
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          if (cmd_rnw) begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_AR;
          end else begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR;
          end
        end
      end
      ST_WR: begin
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = ST_WR_B;
        end
      end
      ST_WR_B: begin
        if (m_axi_bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rnw_d   = 1'b0;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi_bresp;
          state_d     = ST_RSP;
        end
      end
      ST_RD_AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_R;
        end
      end
      ST_RD_R: begin
        if (m_axi_rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rnw_d   = 1'b1;
          rsp_rdata_d = m_axi_rdata;
          rsp_resp_d  = m_axi_rresp;
          state_d     = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rnw_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rnw_q   <= rsp_rnw_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rnw       = rsp_rnw_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awprot  = PROT_DEFAULT;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arprot  = PROT_DEFAULT;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Testbench for axil_cmd_master with a small AXI4-Lite slave model
// (LED register + status word) that has per-channel ready delays.
module tb_axil_cmd_master;

  localparam logic [63:0] LED_OFF     = 64'h0;
  localparam logic [63:0] STATUS_OFF  = 64'h8;
  localparam logic [63:0] STATUS_WORD = 64'h0000_0000_5A7A_0001;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_rnw = 1'b0;
  logic [63:0] cmd_addr = '0, cmd_wdata = '0;
  logic [7:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_rnw;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [63:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  wstrb;
  logic [2:0]  awprot, arprot;
  logic [1:0]  bresp, rresp;

  always #5 aclk = ~aclk;

  axil_cmd_master dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rnw(rsp_rnw),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_awprot(awprot),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
    .m_axi_arprot(arprot),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp)
  );

  // ---------------- slave model ----------------
  int aw_delay = 0, w_delay = 0, ar_delay = 0;
  bit rd_err_mode = 1'b0;
  int aw_cnt, w_cnt, ar_cnt;
  int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0;
  logic aw_got, w_got;
  logic [63:0] aw_addr_l, w_data_l, led_reg;
  logic [7:0]  w_strb_l;
  logic aw_hs, w_hs, ar_hs;

  assign awready = (aw_cnt >= aw_delay);
  assign wready  = (w_cnt  >= w_delay);
  assign arready = (ar_cnt >= ar_delay);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;

  function automatic logic [63:0] apply_strb(logic [63:0] old, logic [63:0] d, logic [7:0] s);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  always @(posedge aclk) begin
    if (!aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00;
      rvalid <= 1'b0; rresp <= 2'b00; rdata <= '0;
      led_reg <= '0;
      aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0;
    end else begin
      if (aw_hs) begin
        aw_cnt <= 0; aw_got <= 1'b1; aw_addr_l <= awaddr; aw_hs_n <= aw_hs_n + 1;
      end else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin
        w_cnt <= 0; w_got <= 1'b1; w_data_l <= wdata; w_strb_l <= wstrb; w_hs_n <= w_hs_n + 1;
      end else if (wvalid) w_cnt <= w_cnt + 1;
      if ((aw_hs || aw_got) && (w_hs || w_got) && !bvalid) begin
        bvalid <= 1'b1;
        bresp  <= 2'b00;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        if ((aw_hs ? awaddr : aw_addr_l) == LED_OFF)
          led_reg <= apply_strb(led_reg, w_hs ? wdata : w_data_l, w_hs ? wstrb : w_strb_l);
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; b_hs_n <= b_hs_n + 1;
      end
      if (ar_hs) begin
        ar_cnt <= 0; ar_hs_n <= ar_hs_n + 1; rvalid <= 1'b1;
        if (rd_err_mode) begin
          rdata <= 64'hDEAD; rresp <= 2'b10;
        end else begin
          rresp <= 2'b00;
          rdata <= (araddr == STATUS_OFF) ? STATUS_WORD :
                   (araddr == LED_OFF) ? led_reg : 64'h0;
        end
      end else if (arvalid) ar_cnt <= ar_cnt + 1;
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- channel protocol monitor ----------------
  // A valid may only fall on its own handshake, its payload must stay put
  // while waiting, and no new valid may follow a handshake directly.
  int   proto_err = 0;
  logic p_rstn = 1'b0, p_awv = 1'b0, p_awhs = 1'b0, p_wv = 1'b0, p_whs = 1'b0;
  logic p_arv = 1'b0, p_arhs = 1'b0;
  logic [63:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;

  always @(posedge aclk) begin
    if (aresetn && p_rstn) begin
      if (p_awv && !p_awhs && (!awvalid || awaddr != p_awaddr)) proto_err <= proto_err + 1;
      else if (p_awhs && awvalid) proto_err <= proto_err + 1;
      else if (p_wv && !p_whs && (!wvalid || wdata != p_wdata)) proto_err <= proto_err + 1;
      else if (p_whs && wvalid) proto_err <= proto_err + 1;
      else if (p_arv && !p_arhs && (!arvalid || araddr != p_araddr)) proto_err <= proto_err + 1;
      else if (p_arhs && arvalid) proto_err <= proto_err + 1;
    end
    p_rstn <= aresetn;
    p_awv <= awvalid; p_awhs <= aw_hs; p_awaddr <= awaddr;
    p_wv <= wvalid;   p_whs <= w_hs;   p_wdata <= wdata;
    p_arv <= arvalid; p_arhs <= ar_hs; p_araddr <= araddr;
  end

  // ---------------- scoreboard / checking ----------------
  typedef struct packed {
    logic        rnw;
    logic [63:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Present a command, push its expected response, wait for acceptance.
  task automatic send_cmd(input logic rnw, input logic [63:0] addr, input logic [63:0] d,
                          input logic [7:0] s, input logic [63:0] exp_rdata,
                          input logic [1:0] exp_resp);
    bit took;
    exp_t e;
    e.rnw = rnw; e.rdata = exp_rdata; e.resp = exp_resp;
    exp_q.push_back(e);
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_wdata = d; cmd_wstrb = s;
    took = 1'b0;
    for (int i = 0; i < 50 && !took; i++) begin
      took = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!took) check("cmd_accept_timeout", 64'd0, 64'd1);
  endtask

  // Compare the current response against the scoreboard head.
  task automatic pop_and_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_rnw"},   {63'd0, rsp_rnw}, {63'd0, e.rnw});
      check({tag, "_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_resp"},  {62'd0, rsp_resp}, {62'd0, e.resp});
    end
  endtask

  // Wait (bounded) for rsp_valid, check it, and let the handshake complete.
  task automatic wait_rsp(input string tag, output int lat);
    lat = 0;
    for (int i = 0; i < 50 && !rsp_valid; i++) begin
      tick();
      lat++;
    end
    if (!rsp_valid) begin
      check({tag, "_rsp_timeout"}, 64'd0, 64'd1);
    end else begin
      pop_and_check(tag);
      if (rsp_ready) tick();
    end
  endtask

  initial begin
    int lat;
    int aw0, w0, b0, ar0;

    // Reset state
    tick(); tick();
    check("rst_outputs", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}, 7'd0);
    check("rst_rsp", {rsp_rnw, rsp_resp, rsp_rdata}, 67'd0);
    check("prot", {awprot, arprot}, 6'd0);
    aresetn = 1'b1;
    tick();
    check("rst_release_cmd_ready", cmd_ready, 1'b1);

    // LED write, zero-wait slave
    send_cmd(1'b0, LED_OFF, 64'hA5, 8'h01, 64'h0, 2'b00);
    check("wr_aw_w_valid_t1", {awvalid, wvalid}, 2'b11);
    check("wr_cmd_ready_drop", cmd_ready, 1'b0);
    wait_rsp("wr_led", lat);
    check("wr_latency", lat, 2);
    check("led_value", led_reg, 64'hA5);

    // Status read
    ar0 = ar_hs_n;
    send_cmd(1'b1, STATUS_OFF, 64'h0, 8'h00, STATUS_WORD, 2'b00);
    check("rd_arvalid_t1", arvalid, 1'b1);
    wait_rsp("rd_status", lat);
    check("rd_latency", lat, 2);
    check("rd_ar_handshakes", ar_hs_n - ar0, 1);

    // AW delayed, W immediate; then reversed
    aw_delay = 3; w_delay = 0;
    aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
    send_cmd(1'b0, LED_OFF, 64'h77, 8'h01, 64'h0, 2'b00);
    wait_rsp("wr_aw_slow", lat);
    check("aw_slow_hs_counts", {aw_hs_n - aw0, w_hs_n - w0, b_hs_n - b0}, {32'd1, 32'd1, 32'd1});
    aw_delay = 0; w_delay = 3;
    aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
    send_cmd(1'b0, LED_OFF, 64'h155, 8'h01, 64'h0, 2'b00);
    wait_rsp("wr_w_slow", lat);
    check("w_slow_hs_counts", {aw_hs_n - aw0, w_hs_n - w0, b_hs_n - b0}, {32'd1, 32'd1, 32'd1});
    w_delay = 0;
    send_cmd(1'b1, LED_OFF, 64'h0, 8'h00, 64'h55, 2'b00);
    wait_rsp("rd_led_strobed", lat);

    // Response back-pressure with a queued second command
    rsp_ready = 1'b0;
    send_cmd(1'b0, LED_OFF, 64'h3C, 8'h01, 64'h0, 2'b00);
    for (int i = 0; i < 20 && !rsp_valid; i++) tick();
    pop_and_check("stall_first");
    send_cmd_hold: begin
      exp_t e;
      e.rnw = 1'b1; e.rdata = 64'h3C; e.resp = 2'b00;
      exp_q.push_back(e);
      cmd_valid = 1'b1; cmd_rnw = 1'b1; cmd_addr = LED_OFF; cmd_wdata = '0; cmd_wstrb = '0;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_rsp_hold", {rsp_valid, rsp_rnw, rsp_resp, rsp_rdata}, {1'b1, 1'b0, 2'b00, 64'h0});
      check("stall_cmd_ready", cmd_ready, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("stall_after_hs", {rsp_valid, cmd_ready}, 2'b01);
    tick();
    check("stall_second_accepted", {cmd_ready, arvalid}, 2'b01);
    cmd_valid = 1'b0;
    wait_rsp("stall_second", lat);

    // SLVERR passthrough on read
    rd_err_mode = 1'b1;
    send_cmd(1'b1, STATUS_OFF, 64'h0, 8'h00, 64'hDEAD, 2'b10);
    wait_rsp("rd_slverr", lat);
    rd_err_mode = 1'b0;

    // Reset while stuck in WR with awvalid high
    aw_delay = 3;
    send_cmd(1'b0, LED_OFF, 64'h11, 8'h01, 64'h0, 2'b00);
    check("midrst_awvalid", awvalid, 1'b1);
    aresetn = 1'b0;
    tick();
    check("midrst_cleared", {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}, 7'd0);
    exp_q.delete();
    aw_delay = 0;
    aresetn = 1'b1;
    tick();
    check("midrst_cmd_ready", cmd_ready, 1'b1);

    // Operation after reset (slave LED register was reset too)
    send_cmd(1'b1, STATUS_OFF, 64'h0, 8'h00, STATUS_WORD, 2'b00);
    wait_rsp("post_rst_rd", lat);
    check("post_rst_latency", lat, 2);

    check("protocol_errors", proto_err, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axil_cmd_master.md
Name: axil_cmd_master

Overview:
- Single-outstanding AXI4-Lite master. Sits directly upstream of nexys_video_gpio_bd and drives its s_axi_* slave port.
- Accepts one register command (address, data, strobe, read/write) on a valid/ready stream and runs exactly one AXI-Lite transaction.
- Returns the result (read data, response code) on a valid/ready response stream.
- Consumed by the test sequencer and, later, the host command bridge, so that LED writes and status reads go through real AXI handshakes.

Parameters:
- AXI_ALEN, 64, address width; must match the downstream slave.
- AXI_DLEN, 64, data width; must match the downstream slave.
- AXI_SLEN, AXI_DLEN/8, write-strobe width.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted this cycle
- cmd_rnw  in  1  1=read, 0=write
- cmd_addr  in  AXI_ALEN  byte address
- cmd_wdata  in  AXI_DLEN  write data (ignored for reads)
- cmd_wstrb  in  AXI_SLEN  write strobes (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rnw  out  1  echo of cmd_rnw
- rsp_rdata  out  AXI_DLEN  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP
- m_axi_awvalid/awready/awaddr/awprot, m_axi_wvalid/wready/wdata/wstrb, m_axi_bvalid/bready/bresp, m_axi_arvalid/arready/araddr/arprot, m_axi_rvalid/rready/rdata/rresp: standard AXI4-Lite master directions; widths are AXI_ALEN, AXI_DLEN, AXI_SLEN, 3 for prot, 2 for resp.

Behaviour:
- Reset is synchronous and active-low on aresetn: one clock, all state cleared at the aclk edge while aresetn=0.
- Reset values: all *valid=0, bready=0, rready=0, cmd_ready=0, rsp_*=0, awprot=arprot=3'b000 (constant). State goes to IDLE.
- FSM states: IDLE, WR, WR_B, RD_AR, RD_R, RSP.
- IDLE:
  - cmd_ready=1 (registered). Command is captured on cmd_valid&cmd_ready.
  - On capture, go to WR (rnw=0) or RD_AR (rnw=1); cmd_ready drops the next cycle.
- WR:
  - awvalid and wvalid both rise the cycle after capture.
  - Each is deasserted independently on its own handshake (aw_done and w_done flags).
  - Address and data are held stable while the matching valid is high.
  - When both are done, go to WR_B with bready=1.
  - AW and W completing in the same cycle or in any order are both legal.
- WR_B: on bvalid&bready, latch bresp, set rsp_rdata=0, bready=0, go to RSP.
- RD_AR: arvalid=1 until arready; then arvalid=0, rready=1, go to RD_R.
- RD_R: on rvalid&rready, latch rdata and rresp, rready=0, go to RSP.
- RSP:
  - rsp_valid=1 with rsp_* held stable until rsp_ready.
  - On the handshake: rsp_valid=0, go to IDLE, cmd_ready=1 next cycle.
  - No back-to-back overlap: at most one transaction in flight.
- Minimum latency with a zero-wait slave:
  - Write: capture at T0, aw/wvalid at T1, bready at T2, bvalid seen T2, rsp_valid T3.
  - Read: capture T0, arvalid T1, rvalid seen T2, rsp_valid T3.
- No valid output depends combinationally on any ready input.
- Error responses (SLVERR/DECERR) are passed through unchanged and are not retried.
- Reset mid-transaction clears everything immediately. The downstream slave shares aresetn, so no orphaned handshake remains.
- cmd_valid during a non-IDLE state is ignored (cmd_ready=0); the command is not lost as long as the upstream holds it.

Decomposition:
- Shared package axil_pkg: AXI resp constants (OKAY=2'b00, EXOKAY, SLVERR, DECERR), the state enum, and a PROT_DEFAULT=3'b000 constant.
- No sub-module. An optional reuse point is a small axil_chan_hold helper for valid-hold-until-ready; inline is acceptable.

Test Plan:
- Write 0xA5 to W_LED_OFFSET with wstrb=0x01 against nexys_video_gpio_bd -> rsp_resp=2'b00, rsp_rdata=0, o_led=0xA5 within 4 cycles of capture.
- Read R_STATUS_OFFSET -> exactly one arvalid handshake; rsp_rdata equals the slave's status word; rsp_resp=0.
- Slave BFM with awready delayed 3 cycles, wready immediate, then reversed -> wvalid/awvalid each drop exactly on their own handshake; one bready handshake; response correct.
- rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready=0 throughout; a second queued command is accepted only the cycle after rsp_ready.
- BFM returns SLVERR (2'b10) on a read with rdata=0xDEAD -> rsp_resp=2'b10, rsp_rdata=0xDEAD.
- aresetn low for 1 cycle while in WR with awvalid=1 -> next cycle all valids/readies=0, state IDLE, cmd_ready=1 the cycle after release.
